exe_mdu: RTL and testbench
==========================

Name: exe_mdu

Overview:
- Multi-cycle multiply/divide unit in the EXE stage, beside the ALU.
- Consumes the same forwarded rs/rt operands (A, B) as the ALU.
- Holds architectural HI/LO; its outputs feed the EXE result mux for mfhi/mflo.
- Drives a busy indication that the hazard unit uses to stall mfhi/mflo/mult/div in ID.

Parameters:
- MULT_CYCLES, 5, busy duration in cycles for mult/multu (>=1)
- DIV_CYCLES, 10, busy duration in cycles for div/divu (>=1)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state
- md_op  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, others none
- A  input  32  forwarded rs operand
- B  input  32  forwarded rt operand
- req  input  1  interrupt/exception request from CP0; suppresses a new issue this cycle
- busy  output  1  operation in flight
- HI  output  32  architectural HI
- LO  output  32  architectural LO

Behaviour:
- Clocking: one clock (clk); reset is asynchronous and active-high.
- Reset: busy=0, HI=0, LO=0, counter=0, pending result cleared. Reset mid-operation aborts it; HI/LO read 0 afterwards.
- States: IDLE and RUN.
- Issue: the unit accepts md_op in 1..6 only when in IDLE and req=0. If busy=1 or req=1, md_op is ignored; the hazard unit guarantees no issue while busy.
- mthi/mtlo: at the issuing edge, HI<=A or LO<=A. busy stays 0; the new value is visible the next cycle.
- mult/multu/div/divu:
  - At the issuing edge, the full result is computed from A/B and latched into pending_hi/pending_lo.
  - counter<=MULT_CYCLES or DIV_CYCLES; state goes to RUN; busy=1 from the next cycle.
- RUN: counter decrements each edge. On the edge where counter reaches 0 (counter==1 before the edge), HI/LO<=pending and the state returns to IDLE. busy is therefore high for exactly N cycles after the issuing edge.
- HI/LO hold their old values throughout RUN. New values appear in the same cycle busy falls.
- Back-to-back: an issue is accepted in the first IDLE cycle (busy=0).
- req during RUN does not cancel; the operation completes (the instruction is already past EXE).
- Arithmetic:
  - mult: signed 32x32->64; HI=[63:32], LO=[31:0].
  - multu: unsigned 32x32->64, same split.
  - div: LO=quotient truncated toward zero; HI=remainder, sign of dividend.
  - divu: unsigned quotient in LO, remainder in HI.
  - Divide by zero (B==0): busy runs the full DIV_CYCLES; HI/LO unchanged at completion.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (no trap).
- Simultaneous reset with anything: reset wins.

Decomposition:
- md_op encodings (MD_NONE..MD_MTLO) are new `define constants in the shared Op.v alongside the alu_* codes.
- MULT_CYCLES/DIV_CYCLES are module parameters.
- One combinational sub-module, md_core (A, B, md_op -> 64-bit result), is natural. The divide-by-zero flag stays in exe_mdu.
- The counter/FSM and HI/LO registers stay in exe_mdu.

Test Plan:
- mult A=0xFFFFFFFF B=2 -> busy high 5 cycles, then HI=0xFFFFFFFF LO=0xFFFFFFFE; HI/LO unchanged while busy.
- multu A=0xFFFFFFFF B=2 -> HI=0x00000001 LO=0xFFFFFFFE.
- div A=0xFFFFFFF9(-7) B=2 -> busy 10 cycles, then LO=0xFFFFFFFD HI=0xFFFFFFFF; divu same operands -> LO=0x7FFFFFFC HI=0x00000001.
- Edge cases:
  - div by B=0 with HI=0x11, LO=0x22 preloaded via mthi/mtlo -> busy 10 cycles, HI/LO stay 0x11/0x22.
  - 0x80000000 / -1 -> LO=0x80000000 HI=0.
- mtlo A=0x1234 with req=1 -> LO unchanged.
- mult issued with req=1 -> busy never rises.
- req asserted mid-RUN -> result still committed.
- reset asserted at cycle 3 of a div -> busy=0, HI=LO=0 immediately (async, before next edge).
- md_op=mult held while busy -> second op ignored; a fresh mult in the first busy=0 cycle is accepted.

Source files
------------

// File: rtl/exe_mdu_pkg.sv
// exe_mdu_pkg: shared types and constants for the EXE-stage multiply/divide unit.
//   md_op_e  - operation codes carried on md_op (values 7..15 mean "none")
//   mdu_state_e - IDLE/RUN sequencing states
//   count_t  - busy-cycle down-counter type
package exe_mdu_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6
  } md_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mdu_state_e;

  localparam int CNT_W = 16;
  typedef logic [CNT_W-1:0] count_t;

endpackage

// File: rtl/exe_mdu_if.sv
// exe_mdu_if: bundles the operand/control inputs and HI/LO/busy outputs of exe_mdu.
//   md_op  - operation code (see exe_mdu_pkg::md_op_e)
//   A, B   - forwarded rs/rt operands
//   req    - CP0 interrupt/exception request, blocks a new issue
//   busy   - multi-cycle operation in flight
//   HI, LO - architectural HI/LO registers
// master: the EXE stage driving operands; slave: the MDU itself.
interface exe_mdu_if;
  logic [3:0]  md_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        req;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (output md_op, A, B, req, input busy, HI, LO);
  modport slave  (input md_op, A, B, req, output busy, HI, LO);
endinterface

// File: rtl/exe_mdu_core.sv
// md_core: purely combinational arithmetic for exe_mdu.
//   i_op     - operation code (only mult/multu/div/divu produce a result)
//   i_a, i_b - operands
//   o_result - {HI, LO}: product for multiplies, {remainder, quotient} for divides
// A zero divisor yields 0; the caller decides to discard it.
module md_core
  import exe_mdu_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [63:0] o_result
);

  logic        w_signedDiv;
  logic [63:0] w_mulA;
  logic [63:0] w_mulB;
  logic [63:0] w_prod;
  logic [31:0] w_dividend;
  logic [31:0] w_divisor;
  logic [31:0] w_quot;
  logic [31:0] w_rem;
  logic [31:0] w_quotFix;
  logic [31:0] w_remFix;

  // One shared multiplier and one shared unsigned divider. The low 64 bits of a
  // product of sign-extended operands equal the signed product, so mult only
  // differs from multu in how the operands are extended. Signed divide runs on
  // magnitudes and restores signs afterwards; this also makes 0x80000000 / -1
  // come out as 0x80000000 without any special case.
  always_comb begin
    w_signedDiv = (i_op == MD_DIV);

    if (i_op == MD_MULT) begin
      w_mulA = {{32{i_a[31]}}, i_a};
      w_mulB = {{32{i_b[31]}}, i_b};
    end else begin
      w_mulA = {32'd0, i_a};
      w_mulB = {32'd0, i_b};
    end
    w_prod = w_mulA * w_mulB;

    w_dividend = (w_signedDiv && i_a[31]) ? (~i_a + 32'd1) : i_a;
    w_divisor  = (w_signedDiv && i_b[31]) ? (~i_b + 32'd1) : i_b;

    if (w_divisor == 32'd0) begin
      w_quot = 32'd0;
      w_rem  = 32'd0;
    end else begin
      w_quot = w_dividend / w_divisor;
      w_rem  = w_dividend % w_divisor;
    end

    w_quotFix = (w_signedDiv && (i_a[31] ^ i_b[31])) ? (~w_quot + 32'd1) : w_quot;
    w_remFix  = (w_signedDiv && i_a[31]) ? (~w_rem + 32'd1) : w_rem;

    case (i_op)
      MD_MULT, MD_MULTU: o_result = w_prod;
      MD_DIV, MD_DIVU:   o_result = {w_remFix, w_quotFix};
      default:           o_result = 64'd0;
    endcase
  end

endmodule

// File: rtl/exe_mdu.sv
// exe_mdu: multi-cycle multiply/divide unit beside the EXE-stage ALU.
//   clk   - system clock, rising edge
//   reset - asynchronous active-high reset, clears HI/LO and aborts any operation
//   mdu   - exe_mdu_if slave port (md_op, A, B, req in; busy, HI, LO out)
// The full result is computed at the issuing edge and parked in a pending
// register; busy then stays high for exactly MULT_CYCLES/DIV_CYCLES cycles and
// HI/LO take the pending value on the edge that drops busy.
module exe_mdu
  import exe_mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  exe_mdu_if.slave   mdu
);

  mdu_state_e  r_state;
  mdu_state_e  w_nextState;
  count_t      r_count;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_pendHi;
  logic [31:0] r_pendLo;
  logic        r_divZero;
  logic [63:0] w_result;
  logic        w_issue;
  logic        w_issueLong;
  logic        w_isMult;
  logic        w_isDiv;
  logic        w_commit;
  logic        w_busy;

  md_core u_core (
    .i_op     (mdu.md_op),
    .i_a      (mdu.A),
    .i_b      (mdu.B),
    .o_result (w_result)
  );

  // Issue decode: only codes 1..6 are operations, and only from IDLE with no
  // pending CP0 request. A request during RUN does not affect the operation.
  always_comb begin
    w_isMult    = (mdu.md_op == MD_MULT) || (mdu.md_op == MD_MULTU);
    w_isDiv     = (mdu.md_op == MD_DIV)  || (mdu.md_op == MD_DIVU);
    w_issue     = (r_state == IDLE) && !mdu.req &&
                  (mdu.md_op >= 4'd1) && (mdu.md_op <= 4'd6);
    w_issueLong = w_issue && (w_isMult || w_isDiv);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_issueLong) w_nextState = RUN;
      RUN:     if (r_count == count_t'(1)) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    w_busy   = (r_state == RUN);
    w_commit = (r_state == RUN) && (r_count == count_t'(1));
  end

  // Datapath: mthi/mtlo write straight through; long ops latch the result and
  // the cycle budget. A divide by zero still burns the full budget but leaves
  // HI/LO untouched at completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count   <= '0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_pendHi  <= 32'd0;
      r_pendLo  <= 32'd0;
      r_divZero <= 1'b0;
    end else if (w_issue) begin
      if (mdu.md_op == MD_MTHI) r_hi <= mdu.A;
      if (mdu.md_op == MD_MTLO) r_lo <= mdu.A;
      if (w_isMult || w_isDiv) begin
        r_pendHi  <= w_result[63:32];
        r_pendLo  <= w_result[31:0];
        r_count   <= w_isMult ? count_t'(MULT_CYCLES) : count_t'(DIV_CYCLES);
        r_divZero <= w_isDiv && (mdu.B == 32'd0);
      end
    end else if (r_state == RUN) begin
      r_count <= r_count - count_t'(1);
      if (w_commit && !r_divZero) begin
        r_hi <= r_pendHi;
        r_lo <= r_pendLo;
      end
    end
  end

  assign mdu.busy = w_busy;
  assign mdu.HI   = r_hi;
  assign mdu.LO   = r_lo;

endmodule

// File: tb/tb_exe_mdu.sv
// tb_exe_mdu: self-checking bench for exe_mdu. Directed cases plus randomized
// operations, all checked against an arithmetic reference model of HI/LO and
// of the busy duration.
module tb_exe_mdu;
  import exe_mdu_pkg::*;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;
  logic [31:0] refHi;
  logic [31:0] refLo;

  exe_mdu_if mduIf ();

  exe_mdu #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk   (clk),
    .reset (reset),
    .mdu   (mduIf)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: MIPS mult/div semantics in plain 64-bit arithmetic.
  function automatic void model(input logic [3:0] op, input logic [31:0] a,
                                input logic [31:0] b,
                                inout logic [31:0] hi, inout logic [31:0] lo);
    longint      sa;
    longint      sb;
    longint      sp;
    longint      sq;
    longint      sr;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      4'd1: begin sp = sa * sb; hi = sp[63:32]; lo = sp[31:0]; end
      4'd2: begin up = {32'd0, a} * {32'd0, b}; hi = up[63:32]; lo = up[31:0]; end
      4'd3: if (b != 32'd0) begin
              sq = sa / sb; sr = sa % sb; lo = sq[31:0]; hi = sr[31:0];
            end
      4'd4: if (b != 32'd0) begin lo = a / b; hi = a % b; end
      4'd5: hi = a;
      4'd6: lo = a;
      default: ;
    endcase
  endfunction

  // Steps and inputs are applied 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic rq);
    mduIf.md_op = op;
    mduIf.A     = a;
    mduIf.B     = b;
    mduIf.req   = rq;
  endtask

  task automatic checkOutput(input string tag, input logic expBusy,
                             input logic [31:0] expHi, input logic [31:0] expLo);
    vectors++;
    assert ({mduIf.busy, mduIf.HI, mduIf.LO} === {expBusy, expHi, expLo})
    else begin
      miscompares++;
      $error("[TB] FAIL %s: busy/HI/LO got %b/%h/%h want %b/%h/%h", tag,
             mduIf.busy, mduIf.HI, mduIf.LO, expBusy, expHi, expLo);
    end
  endtask

  // Issue a long op, check busy for its full duration with HI/LO frozen, then
  // check the committed result. Optionally raise req mid-run, and optionally
  // keep a (different) op on the inputs while busy.
  task automatic runOp(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int reqAt,
                       input logic [3:0] holdOp, input logic [31:0] holdA,
                       input logic [31:0] holdB);
    logic [31:0] nh;
    logic [31:0] nl;
    int          n;
    nh = refHi;
    nl = refLo;
    model(op, a, b, nh, nl);
    n = (op == MD_MULT || op == MD_MULTU) ? MULT_N : DIV_N;
    applyStimulus(op, a, b, 1'b0);
    tick();
    applyStimulus(holdOp, holdA, holdB, 1'b0);
    for (int i = 0; i < n; i++) begin
      if (i == reqAt) mduIf.req = 1'b1;
      checkOutput({tag, "_busy"}, 1'b1, refHi, refLo);
      tick();
    end
    mduIf.req = 1'b0;
    refHi = nh;
    refLo = nl;
    checkOutput({tag, "_done"}, 1'b0, refHi, refLo);
  endtask

  task automatic mtOp(input string tag, input logic [3:0] op, input logic [31:0] a,
                      input logic rq);
    applyStimulus(op, a, 32'd0, rq);
    tick();
    applyStimulus(MD_NONE, 32'd0, 32'd0, 1'b0);
    if (!rq) model(op, a, 32'd0, refHi, refLo);
    checkOutput(tag, 1'b0, refHi, refLo);
  endtask

  initial begin
    logic [3:0]  sel;
    logic [31:0] ra;
    logic [31:0] rb;
    vectors     = 0;
    miscompares = 0;
    refHi       = 32'd0;
    refLo       = 32'd0;
    reset       = 1'b1;
    applyStimulus(MD_NONE, 32'd0, 32'd0, 1'b0);
    tick();
    tick();
    checkOutput("reset_state", 1'b0, 32'd0, 32'd0);
    reset = 1'b0;
    tick();

    runOp("mult", MD_MULT, 32'hFFFF_FFFF, 32'd2, -1, MD_NONE, 32'd0, 32'd0);
    runOp("multu", MD_MULTU, 32'hFFFF_FFFF, 32'd2, -1, MD_NONE, 32'd0, 32'd0);
    runOp("div", MD_DIV, 32'hFFFF_FFF9, 32'd2, -1, MD_NONE, 32'd0, 32'd0);
    runOp("divu", MD_DIVU, 32'hFFFF_FFF9, 32'd2, -1, MD_NONE, 32'd0, 32'd0);

    mtOp("mthi", MD_MTHI, 32'h11, 1'b0);
    mtOp("mtlo", MD_MTLO, 32'h22, 1'b0);
    runOp("div0", MD_DIV, 32'd1234, 32'd0, -1, MD_NONE, 32'd0, 32'd0);
    runOp("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1, MD_NONE, 32'd0, 32'd0);

    mtOp("mtlo_req", MD_MTLO, 32'h1234, 1'b1);

    // mult offered with req=1 must never start
    applyStimulus(MD_MULT, 32'd3, 32'd4, 1'b1);
    tick();
    checkOutput("mult_req0", 1'b0, refHi, refLo);
    applyStimulus(MD_NONE, 32'd0, 32'd0, 1'b0);
    tick();
    checkOutput("mult_req1", 1'b0, refHi, refLo);

    runOp("req_mid", MD_MULT, 32'h0001_2345, 32'hFFFF_FF00, 2, MD_NONE, 32'd0, 32'd0);

    // second mult held on the inputs while busy is ignored, then accepted in
    // the first idle cycle
    runOp("hold1", MD_MULT, 32'd7, 32'd9, -1, MD_MULT, 32'h0000_1000, 32'h0000_0300);
    runOp("hold2", MD_MULT, 32'h0000_1000, 32'h0000_0300, -1, MD_NONE, 32'd0, 32'd0);

    // asynchronous reset during cycle 3 of a divide
    applyStimulus(MD_DIV, 32'd1000, 32'd7, 1'b0);
    tick();
    applyStimulus(MD_NONE, 32'd0, 32'd0, 1'b0);
    tick();
    tick();
    checkOutput("rst_mid_busy", 1'b1, refHi, refLo);
    reset = 1'b1;
    #1;
    refHi = 32'd0;
    refLo = 32'd0;
    checkOutput("rst_mid_async", 1'b0, refHi, refLo);
    reset = 1'b0;
    tick();
    checkOutput("rst_mid_after", 1'b0, refHi, refLo);

    // randomized operations
    for (int i = 0; i < 14; i++) begin
      sel = 4'($urandom_range(1, 6));
      ra  = $urandom;
      rb  = $urandom;
      if ($urandom_range(0, 4) == 0) rb = 32'd0;
      if ($urandom_range(0, 6) == 0) begin
        ra = 32'h8000_0000;
        rb = 32'hFFFF_FFFF;
      end
      if (sel >= 4'd5)
        mtOp("rand_mt", sel, ra, 1'($urandom_range(0, 1)));
      else
        runOp("rand_op", sel, ra, rb, -1, MD_NONE, 32'd0, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
